// File: rtl/dcache_wport_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// dcache_wport_arbiter_pkg
//   Shared types and helpers for the dcache write-port arbiter.
//   - cfg_t       : minimal core configuration (physical address / data width)
//   - CfgDefault  : default configuration used when the core does not pass one
//   - arb_state_e : arbiter FSM state encoding
//   - wrap_add    : (a + b) mod n for small operands (a < n, b <= n)
// ---------------------------------------------------------------------------
package dcache_wport_arbiter_pkg;

  typedef struct packed {
    int unsigned PLEN;
    int unsigned XLEN;
  } cfg_t;

  localparam cfg_t CfgDefault = '{PLEN: 32'd56, XLEN: 32'd64};

  localparam int unsigned SIZE_W = 2;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  // Single conditional subtract is enough because both operands stay below n.
  function automatic int unsigned wrap_add(input int unsigned a,
                                           input int unsigned b,
                                           input int unsigned n);
    int unsigned s;
    s = a + b;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/dcache_wport_arbiter_rr_select.sv
// ---------------------------------------------------------------------------
// dcache_wport_arbiter_rr_select
//   Purely combinational round-robin selector with an optional strict-priority
//   override. Reusable by other LSU arbiters.
// Ports:
//   req_i      in  NR_PORTS  request vector
//   ptr_i      in  IDX_W     round-robin start index (first port to consider)
//   prio_en_i  in  1         enable strict priority for prio_idx_i
//   prio_idx_i in  IDX_W     index that wins whenever enabled and requesting
//   valid_o    out 1         at least one request present
//   idx_o      out IDX_W     selected index (0 when valid_o is low)
// ---------------------------------------------------------------------------
module dcache_wport_arbiter_rr_select
  import dcache_wport_arbiter_pkg::*;
#(
  parameter int unsigned NR_PORTS = 2,
  parameter int unsigned IDX_W    = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1
) (
  input  logic [NR_PORTS-1:0] req_i,
  input  logic [IDX_W-1:0]    ptr_i,
  input  logic                prio_en_i,
  input  logic [IDX_W-1:0]    prio_idx_i,
  output logic                valid_o,
  output logic [IDX_W-1:0]    idx_o
);

  always_comb begin
    logic [IDX_W-1:0] cand;
    logic             found;
    valid_o = |req_i;
    idx_o   = '0;
    found   = 1'b0;
    cand    = '0;
    // Walk the ports starting at ptr_i; the first requesting one wins.
    for (int unsigned k = 0; k < NR_PORTS; k++) begin
      cand = IDX_W'(wrap_add(32'(ptr_i), k, NR_PORTS));
      if (!found && req_i[cand]) begin
        idx_o = cand;
        found = 1'b1;
      end
    end
    if (prio_en_i && req_i[prio_idx_i]) begin
      idx_o = prio_idx_i;
    end
  end

endmodule

// File: rtl/dcache_wport_arbiter.sv
// ---------------------------------------------------------------------------
// dcache_wport_arbiter
//   Shares the single dcache write port between store-side requesters
//   (store buffer drain, AMO buffer, CMO/fence writeback). Round-robin
//   selection, grant locking while the cache has not accepted, and an
//   optional strict priority for PRIO_PORT.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   prio_en_i            PRIO_PORT wins ties while high (IDLE only)
//   req_i/addr_i/data_i/be_i/size_i   per-port request and flat payload
//   gnt_o                one-hot grant back to the requester
//   req_o/addr_o/data_o/be_o/size_o/we_o  request towards the dcache
//   gnt_i                dcache accepts the presented request
//   owner_o              last selected port
//   busy_o               a locked request is waiting for gnt_i
// ---------------------------------------------------------------------------
module dcache_wport_arbiter
  import dcache_wport_arbiter_pkg::*;
#(
  parameter cfg_t        CVA6Cfg   = CfgDefault,
  parameter int unsigned NR_PORTS  = 2,
  parameter int unsigned PRIO_PORT = 0,
  localparam int unsigned PLEN  = CVA6Cfg.PLEN,
  localparam int unsigned XLEN  = CVA6Cfg.XLEN,
  localparam int unsigned BE_W  = XLEN / 8,
  localparam int unsigned IDX_W = $clog2(NR_PORTS)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       prio_en_i,
  input  logic [NR_PORTS-1:0]        req_i,
  input  logic [NR_PORTS*PLEN-1:0]   addr_i,
  input  logic [NR_PORTS*XLEN-1:0]   data_i,
  input  logic [NR_PORTS*BE_W-1:0]   be_i,
  input  logic [NR_PORTS*SIZE_W-1:0] size_i,
  output logic [NR_PORTS-1:0]        gnt_o,
  output logic                       req_o,
  output logic [PLEN-1:0]            addr_o,
  output logic [XLEN-1:0]            data_o,
  output logic [BE_W-1:0]            be_o,
  output logic [SIZE_W-1:0]          size_o,
  output logic                       we_o,
  input  logic                       gnt_i,
  output logic [IDX_W-1:0]           owner_o,
  output logic                       busy_o
);

  if (NR_PORTS < 2 || NR_PORTS > 4 || PRIO_PORT >= NR_PORTS) begin : g_bad_cfg
    $error("dcache_wport_arbiter: NR_PORTS must be 2..4 and PRIO_PORT < NR_PORTS");
  end

  localparam logic [IDX_W-1:0] PRIO_IDX = IDX_W'(PRIO_PORT);

  // Per-port payload views of the flat input buses.
  logic [PLEN-1:0]   addr_arr [NR_PORTS];
  logic [XLEN-1:0]   data_arr [NR_PORTS];
  logic [BE_W-1:0]   be_arr   [NR_PORTS];
  logic [SIZE_W-1:0] size_arr [NR_PORTS];

  for (genvar gi = 0; gi < NR_PORTS; gi++) begin : g_slice
    assign addr_arr[gi] = addr_i[gi*PLEN +: PLEN];
    assign data_arr[gi] = data_i[gi*XLEN +: XLEN];
    assign be_arr[gi]   = be_i[gi*BE_W +: BE_W];
    assign size_arr[gi] = size_i[gi*SIZE_W +: SIZE_W];
  end

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic [IDX_W-1:0] owner_q, owner_d;

  logic             sel_valid;
  logic [IDX_W-1:0] sel_idx;
  logic             cur_req;
  logic [IDX_W-1:0] cur_idx;

  dcache_wport_arbiter_rr_select #(
    .NR_PORTS (NR_PORTS),
    .IDX_W    (IDX_W)
  ) u_rr_select (
    .req_i      (req_i),
    .ptr_i      (rr_q),
    .prio_en_i  (prio_en_i),
    .prio_idx_i (PRIO_IDX),
    .valid_o    (sel_valid),
    .idx_o      (sel_idx)
  );

  // While locked only the owner is visible; its own req_i still gates req_o
  // so a protocol-violating drop does not present a stale request.
  always_comb begin
    cur_req = sel_valid;
    cur_idx = sel_idx;
    if (state_q == ST_LOCKED) begin
      cur_req = req_i[owner_q];
      cur_idx = owner_q;
    end
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      rr_q    <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    case (state_q)
      ST_IDLE: begin
        if (sel_valid) begin
          owner_d = sel_idx;
          if (gnt_i) begin
            rr_d = IDX_W'(wrap_add(32'(sel_idx), 32'd1, NR_PORTS));
          end else begin
            state_d = ST_LOCKED;
          end
        end
      end
      ST_LOCKED: begin
        if (!req_i[owner_q]) begin
          state_d = ST_IDLE;
        end else if (gnt_i) begin
          rr_d    = IDX_W'(wrap_add(32'(owner_q), 32'd1, NR_PORTS));
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic. The combinational request path is masked by rst_ni so
  // every output sits at its reset value for the whole reset pulse.
  always_comb begin
    req_o  = 1'b0;
    gnt_o  = '0;
    addr_o = '0;
    data_o = '0;
    be_o   = '0;
    size_o = '0;
    busy_o = (state_q == ST_LOCKED);
    if (rst_ni && cur_req) begin
      req_o  = 1'b1;
      addr_o = addr_arr[cur_idx];
      data_o = data_arr[cur_idx];
      be_o   = be_arr[cur_idx];
      size_o = size_arr[cur_idx];
      if (gnt_i) begin
        gnt_o[cur_idx] = 1'b1;
      end
    end
  end

  assign we_o    = 1'b1;
  assign owner_o = owner_q;

  // A locked owner must keep requesting until it is granted.
  a_owner_holds_req : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (state_q == ST_LOCKED) |-> req_i[owner_q]
  ) else $error("dcache_wport_arbiter: locked owner dropped its request");

  a_gnt_onehot : assert property (
    @(posedge clk_i) disable iff (!rst_ni) $onehot0(gnt_o)
  ) else $error("dcache_wport_arbiter: gnt_o not one-hot");

endmodule

// File: tb/tb_dcache_wport_arbiter.sv
module tb_dcache_wport_arbiter;
  import dcache_wport_arbiter_pkg::*;

  localparam int N    = 4;
  localparam int PRIO = 2;
  localparam int PLEN = 32;
  localparam int XLEN = 32;
  localparam int BE_W = XLEN / 8;
  localparam cfg_t TB_CFG = '{PLEN: 32'd32, XLEN: 32'd32};

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 prio_en;
  logic [N-1:0]         req;
  logic [N*PLEN-1:0]    addr_flat;
  logic [N*XLEN-1:0]    data_flat;
  logic [N*BE_W-1:0]    be_flat;
  logic [N*2-1:0]       size_flat;
  logic [N-1:0]         gnt_o;
  logic                 req_o;
  logic [PLEN-1:0]      addr_o;
  logic [XLEN-1:0]      data_o;
  logic [BE_W-1:0]      be_o;
  logic [1:0]           size_o;
  logic                 we_o;
  logic                 gnt_in;
  logic [1:0]           owner_o;
  logic                 busy_o;

  logic [PLEN-1:0] p_addr [N];
  logic [XLEN-1:0] p_data [N];
  logic [BE_W-1:0] p_be   [N];
  logic [1:0]      p_size [N];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dcache_wport_arbiter #(
    .CVA6Cfg   (TB_CFG),
    .NR_PORTS  (N),
    .PRIO_PORT (PRIO)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .prio_en_i (prio_en),
    .req_i     (req),
    .addr_i    (addr_flat),
    .data_i    (data_flat),
    .be_i      (be_flat),
    .size_i    (size_flat),
    .gnt_o     (gnt_o),
    .req_o     (req_o),
    .addr_o    (addr_o),
    .data_o    (data_o),
    .be_o      (be_o),
    .size_o    (size_o),
    .we_o      (we_o),
    .gnt_i     (gnt_in),
    .owner_o   (owner_o),
    .busy_o    (busy_o)
  );

  task automatic pack_payload();
    for (int k = 0; k < N; k++) begin
      addr_flat[k*PLEN +: PLEN] = p_addr[k];
      data_flat[k*XLEN +: XLEN] = p_data[k];
      be_flat[k*BE_W +: BE_W]   = p_be[k];
      size_flat[k*2 +: 2]       = p_size[k];
    end
  endtask

  // Port k: addr 0x8000_0010 + k*0x100, data 0xD000_000k, be one-hot k, size k.
  task automatic default_payload();
    for (int k = 0; k < N; k++) begin
      p_addr[k] = 32'h8000_0010 + 32'(k * 256);
      p_data[k] = 32'hD000_0000 + 32'(k);
      p_be[k]   = 4'(1 << k);
      p_size[k] = 2'(k);
    end
    pack_payload();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req = '0; gnt_in = 1'b0; prio_en = 1'b0;
    default_payload();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drive one cycle of stimulus on the falling edge, settle, then return
  // so the caller can compare the combinational outputs.
  task automatic step(input logic [N-1:0] r, input logic g, input logic pe);
    @(negedge clk);
    req = r; gnt_in = g; prio_en = pe;
    pack_payload();
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; req = '0; gnt_in = 1'b0; prio_en = 1'b0;
    default_payload();
    #1;
    total++; if (req_o !== 1'b0) begin bad++; $display("FAIL reset.req_o got=%b want=0", req_o); end
    total++; if (gnt_o !== 4'b0) begin bad++; $display("FAIL reset.gnt_o got=%b want=0000", gnt_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset.busy_o got=%b want=0", busy_o); end
    total++; if (owner_o !== 2'd0) begin bad++; $display("FAIL reset.owner_o got=%0d want=0", owner_o); end
    total++; if ({addr_o, data_o, be_o, size_o} !== '0) begin bad++; $display("FAIL reset.payload got=%h/%h/%h/%h want=0", addr_o, data_o, be_o, size_o); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (req_o !== 1'b0 || busy_o !== 1'b0) begin bad++; $display("FAIL reset.after_release got req=%b busy=%b want 0/0", req_o, busy_o); end
    $display("reset: outputs idle");
  endtask

  task automatic test_single();
    do_reset();
    step(4'b0001, 1'b1, 1'b0);
    total++; if (req_o !== 1'b1) begin bad++; $display("FAIL single.req_o got=%b want=1", req_o); end
    total++; if (gnt_o !== 4'b0001) begin bad++; $display("FAIL single.gnt_o got=%b want=0001", gnt_o); end
    total++; if (addr_o !== 32'h8000_0010) begin bad++; $display("FAIL single.addr_o got=%h want=80000010", addr_o); end
    total++; if (data_o !== 32'hD000_0000 || be_o !== 4'b0001 || size_o !== 2'd0 || we_o !== 1'b1) begin bad++; $display("FAIL single.payload got=%h/%b/%0d we=%b", data_o, be_o, size_o, we_o); end
    $display("single: gnt=%b addr=%h", gnt_o, addr_o);
    // rr now points at port 1, so it beats port 0.
    step(4'b0011, 1'b1, 1'b0);
    total++; if (gnt_o !== 4'b0010) begin bad++; $display("FAIL single.rr_next got=%b want=0010", gnt_o); end
    total++; if (addr_o !== 32'h8000_0110) begin bad++; $display("FAIL single.addr1 got=%h want=80000110", addr_o); end
    total++; if (owner_o !== 2'd0) begin bad++; $display("FAIL single.owner0 got=%0d want=0", owner_o); end
    $display("single: gnt=%b addr=%h", gnt_o, addr_o);
    step(4'b0000, 1'b0, 1'b0);
    total++; if (owner_o !== 2'd1) begin bad++; $display("FAIL single.owner1 got=%0d want=1", owner_o); end
    total++; if (req_o !== 1'b0 || addr_o !== 32'h0) begin bad++; $display("FAIL single.idle got req=%b addr=%h want 0/0", req_o, addr_o); end
  endtask

  task automatic test_lock_hold();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      step(4'b0001, 1'b0, 1'b0);
      total++; if (busy_o !== (c != 0)) begin bad++; $display("FAIL lock.busy c%0d got=%b want=%b", c, busy_o, (c != 0)); end
      total++; if (req_o !== 1'b1 || gnt_o !== 4'b0) begin bad++; $display("FAIL lock.wait c%0d got req=%b gnt=%b want 1/0000", c, req_o, gnt_o); end
      total++; if (addr_o !== 32'h8000_0010) begin bad++; $display("FAIL lock.addr c%0d got=%h want=80000010", c, addr_o); end
      $display("lock: cycle %0d waiting busy=%b", c, busy_o);
    end
    step(4'b0011, 1'b1, 1'b0);
    total++; if (gnt_o !== 4'b0001 || addr_o !== 32'h8000_0010) begin bad++; $display("FAIL lock.grant got gnt=%b addr=%h want 0001/80000010", gnt_o, addr_o); end
    $display("lock: gnt=%b addr=%h", gnt_o, addr_o);
    step(4'b0010, 1'b1, 1'b0);
    total++; if (gnt_o !== 4'b0010 || addr_o !== 32'h8000_0110 || busy_o !== 1'b0) begin bad++; $display("FAIL lock.next got gnt=%b addr=%h busy=%b want 0010/80000110/0", gnt_o, addr_o, busy_o); end
    $display("lock: gnt=%b addr=%h", gnt_o, addr_o);
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] exp2 [4];
    logic [N-1:0] exp3 [6];
    exp2 = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};
    exp3 = '{4'b0001, 4'b0010, 4'b0100, 4'b0001, 4'b0010, 4'b0100};
    do_reset();
    for (int c = 0; c < 4; c++) begin
      step(4'b0011, 1'b1, 1'b0);
      total++; if (gnt_o !== exp2[c]) begin bad++; $display("FAIL fair2.c%0d got=%b want=%b", c, gnt_o, exp2[c]); end
      $display("fair2: gnt=%b", gnt_o);
    end
    do_reset();
    for (int c = 0; c < 6; c++) begin
      step(4'b0111, 1'b1, 1'b0);
      total++; if (gnt_o !== exp3[c]) begin bad++; $display("FAIL fair3.c%0d got=%b want=%b", c, gnt_o, exp3[c]); end
      $display("fair3: gnt=%b", gnt_o);
    end
  endtask

  task automatic test_priority();
    logic [N-1:0] exp [4];
    exp = '{4'b0100, 4'b0001, 4'b0010, 4'b0100};
    do_reset();
    for (int c = 0; c < 4; c++) begin
      step(4'b0111, 1'b1, (c == 0));
      total++; if (gnt_o !== exp[c]) begin bad++; $display("FAIL prio.seq c%0d got=%b want=%b", c, gnt_o, exp[c]); end
      $display("prio: gnt=%b", gnt_o);
    end
    // prio_en_i rising while locked waits for the current grant.
    do_reset();
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0101, 1'b0, 1'b1);
    total++; if (gnt_o !== 4'b0000 || addr_o !== 32'h8000_0010 || busy_o !== 1'b1) begin bad++; $display("FAIL prio.locked got gnt=%b addr=%h busy=%b", gnt_o, addr_o, busy_o); end
    step(4'b0101, 1'b1, 1'b1);
    total++; if (gnt_o !== 4'b0001) begin bad++; $display("FAIL prio.locked_gnt got=%b want=0001", gnt_o); end
    step(4'b0100, 1'b1, 1'b1);
    total++; if (gnt_o !== 4'b0100) begin bad++; $display("FAIL prio.after_lock got=%b want=0100", gnt_o); end
    // Priority port idle: plain round-robin; rr=3 after the port-2 grant.
    step(4'b0011, 1'b1, 1'b1);
    total++; if (gnt_o !== 4'b0001) begin bad++; $display("FAIL prio.absent got=%b want=0001", gnt_o); end
    // rr=1 now, but the priority port overrides it.
    step(4'b1110, 1'b1, 1'b1);
    total++; if (gnt_o !== 4'b0100) begin bad++; $display("FAIL prio.override got=%b want=0100", gnt_o); end
    $display("prio: locked/override cases done");
  endtask

  task automatic test_wrap();
    do_reset();
    step(4'b0100, 1'b1, 1'b0);
    step(4'b0001, 1'b1, 1'b0);
    total++; if (gnt_o !== 4'b0001) begin bad++; $display("FAIL wrap.port0 got=%b want=0001", gnt_o); end
    step(4'b1111, 1'b1, 1'b0);
    total++; if (gnt_o !== 4'b0010) begin bad++; $display("FAIL wrap.rr1 got=%b want=0010", gnt_o); end
    step(4'b1000, 1'b1, 1'b0);
    step(4'b1001, 1'b1, 1'b0);
    total++; if (gnt_o !== 4'b0001) begin bad++; $display("FAIL wrap.from3 got=%b want=0001", gnt_o); end
    $display("wrap: gnt=%b", gnt_o);
  endtask

  task automatic test_reset_mid_lock();
    do_reset();
    step(4'b0010, 1'b1, 1'b0);
    step(4'b0010, 1'b0, 1'b0);
    step(4'b0010, 1'b0, 1'b0);
    total++; if (busy_o !== 1'b1 || owner_o !== 2'd1) begin bad++; $display("FAIL midrst.locked got busy=%b owner=%0d want 1/1", busy_o, owner_o); end
    @(negedge clk);
    rst_n = 1'b0; gnt_in = 1'b1;
    #1;
    total++; if (req_o !== 1'b0 || busy_o !== 1'b0 || gnt_o !== 4'b0) begin bad++; $display("FAIL midrst.in_reset got req=%b busy=%b gnt=%b want 0/0/0000", req_o, busy_o, gnt_o); end
    total++; if (owner_o !== 2'd0 || addr_o !== 32'h0) begin bad++; $display("FAIL midrst.outputs got owner=%0d addr=%h want 0/0", owner_o, addr_o); end
    @(negedge clk);
    req = '0; gnt_in = 1'b0; rst_n = 1'b1;
    #1;
    total++; if (busy_o !== 1'b0 || req_o !== 1'b0) begin bad++; $display("FAIL midrst.release got busy=%b req=%b want 0/0", busy_o, req_o); end
    // rr was 2 before reset; after reset it restarts at 0 so port 1 wins.
    step(4'b0110, 1'b1, 1'b0);
    total++; if (gnt_o !== 4'b0010) begin bad++; $display("FAIL midrst.rr_reset got=%b want=0010", gnt_o); end
    $display("midrst: gnt=%b", gnt_o);
  endtask

  // Randomised traffic against a transaction-level model: requesters obey the
  // hold-until-grant contract; the model tracks lock, rotation and last owner.
  task automatic test_random();
    bit           pend [N];
    bit           m_locked;
    int           m_owner, m_rr, m_last, w, p;
    logic [N-1:0] exp_gnt;
    logic [PLEN-1:0] exp_addr;
    logic [XLEN-1:0] exp_data;
    logic [BE_W-1:0] exp_be;
    logic [1:0]      exp_size;
    do_reset();
    m_locked = 1'b0; m_owner = 0; m_rr = 0; m_last = 0;
    for (int k = 0; k < N; k++) pend[k] = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        if (!pend[k] && $urandom_range(0, 2) == 0) begin
          pend[k] = 1'b1;
          p_addr[k] = $urandom; p_data[k] = $urandom;
          p_be[k] = 4'($urandom); p_size[k] = 2'($urandom);
        end
        req[k] = pend[k];
      end
      gnt_in  = ($urandom_range(0, 3) != 0);
      prio_en = ($urandom_range(0, 3) == 0);
      pack_payload();
      #1;
      w = -1;
      if (m_locked) w = m_owner;
      else if (prio_en && pend[PRIO]) w = PRIO;
      else begin
        for (int k = 0; k < N; k++) begin
          p = (m_rr + k) % N;
          if (w < 0 && pend[p]) w = p;
        end
      end
      exp_gnt = '0; exp_addr = '0; exp_data = '0; exp_be = '0; exp_size = '0;
      if (w >= 0) begin
        exp_addr = p_addr[w]; exp_data = p_data[w]; exp_be = p_be[w]; exp_size = p_size[w];
        if (gnt_in) exp_gnt[w] = 1'b1;
      end
      total++; if (req_o !== (w >= 0)) begin bad++; $display("FAIL rand.req_o c%0d got=%b want=%b", c, req_o, (w >= 0)); end
      total++; if (gnt_o !== exp_gnt) begin bad++; $display("FAIL rand.gnt_o c%0d got=%b want=%b", c, gnt_o, exp_gnt); end
      total++; if (busy_o !== m_locked) begin bad++; $display("FAIL rand.busy_o c%0d got=%b want=%b", c, busy_o, m_locked); end
      total++; if (owner_o !== 2'(m_last)) begin bad++; $display("FAIL rand.owner_o c%0d got=%0d want=%0d", c, owner_o, m_last); end
      total++; if (addr_o !== exp_addr || data_o !== exp_data) begin bad++; $display("FAIL rand.addr_data c%0d got=%h/%h want=%h/%h", c, addr_o, data_o, exp_addr, exp_data); end
      total++; if (be_o !== exp_be || size_o !== exp_size) begin bad++; $display("FAIL rand.be_size c%0d got=%b/%0d want=%b/%0d", c, be_o, size_o, exp_be, exp_size); end
      if (w >= 0) begin
        m_last = w;
        if (gnt_in) begin
          $display("rand: c%0d grant port %0d addr=%h", c, w, exp_addr);
          m_rr = (w + 1) % N;
          m_locked = 1'b0;
          pend[w] = 1'b0;
        end else begin
          m_locked = 1'b1;
          m_owner = w;
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; req = '0; gnt_in = 1'b0; prio_en = 1'b0;
    default_payload();
    test_reset();
    test_single();
    test_lock_hold();
    test_back_to_back();
    test_priority();
    test_wrap();
    test_reset_mid_lock();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
